// File: rtl/traffic_light_conflict_monitor_if.sv
// traffic_light_conflict_monitor_if: controller head codes in, lamp drive and fault status out
interface traffic_light_conflict_monitor_if;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic fault_clr;
  logic [2:0] lamp_M1, lamp_M2, lamp_MT, lamp_S;
  logic fault;
  logic [2:0] fault_code;
  modport master (
    output light_M1, light_M2, light_MT, light_S, fault_clr,
    input lamp_M1, lamp_M2, lamp_MT, lamp_S, fault, fault_code
  );
  modport slave (
    input light_M1, light_M2, light_MT, light_S, fault_clr,
    output lamp_M1, lamp_M2, lamp_MT, lamp_S, fault, fault_code
  );
endinterface

// File: rtl/traffic_light_conflict_monitor.sv
// traffic_light_conflict_monitor: registers head codes to lamps, latches first fault and flashes red
module traffic_light_conflict_monitor #(
  parameter int MIN_YELLOW = 2,
  parameter int WATCHDOG = 16,
  parameter int FLASH_HALF = 4
) (
  input logic clk,
  input logic rst,
  traffic_light_conflict_monitor_if.slave bus
);
  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int WW = $clog2(WATCHDOG + 1);
  localparam int FW = $clog2(2 * FLASH_HALF);
  localparam logic [YW-1:0] MY = YW'(MIN_YELLOW);
  localparam logic [2:0] G = 3'b001, Y = 3'b010, R = 3'b100;
  typedef enum logic [1:0] {ARMING, MONITOR, FAULT} state_t;
  state_t state;
  logic [3:0][2:0] cur, prev, lamp;
  logic [3:0][YW-1:0] ycnt, ynext;
  logic [3:0] nr;
  logic [WW-1:0] wd;
  logic [FW-1:0] flash, flash_nxt;
  logic enc_bad, conflict, seq_bad, short_y, same, wd_fire, fault;
  logic [2:0] cause, fault_code;
  assign cur = {bus.light_S, bus.light_MT, bus.light_M2, bus.light_M1};
  assign {bus.lamp_S, bus.lamp_MT, bus.lamp_M2, bus.lamp_M1} = lamp;
  assign bus.fault = fault;
  assign bus.fault_code = fault_code;
  always_comb begin
    enc_bad = 1'b0;
    seq_bad = 1'b0;
    short_y = 1'b0;
    nr = '0;
    ynext = '0;
    for (int i = 0; i < 4; i++) begin
      nr[i] = cur[i] != R;
      enc_bad |= !(cur[i] == G || cur[i] == Y || cur[i] == R);
      seq_bad |= (prev[i] == G && cur[i] == R) || (prev[i] == Y && cur[i] == G) ||
                 (prev[i] == R && cur[i] == Y);
      short_y |= prev[i] == Y && cur[i] == R && ycnt[i] < MY;
      ynext[i] = cur[i] == Y ? (ycnt[i] == MY ? MY : ycnt[i] + 1'b1) : '0;
    end
  end
  // S excludes every main head; MT excludes M2; M1 may run with either
  assign conflict = (nr[3] & |nr[2:0]) | (nr[2] & nr[1]);
  assign same = cur == prev;
  assign wd_fire = same && wd == WW'(WATCHDOG - 1);
  assign cause = enc_bad ? 3'd1 : conflict ? 3'd2 : seq_bad ? 3'd3 : short_y ? 3'd4 :
                 wd_fire ? 3'd5 : 3'd0;
  assign flash_nxt = flash == FW'(2 * FLASH_HALF - 1) ? '0 : flash + 1'b1;
  always_ff @(posedge clk) begin
    if (rst || (state == FAULT && bus.fault_clr)) begin
      state <= ARMING;
      lamp <= {4{R}};
      prev <= {4{R}};
      fault <= 1'b0;
      fault_code <= 3'd0;
      ycnt <= '0;
      wd <= '0;
      flash <= '0;
    end else if (state == FAULT) begin
      flash <= flash_nxt;
      lamp <= flash_nxt < FW'(FLASH_HALF) ? {4{R}} : '0;
    end else begin
      prev <= cur;
      ycnt <= ynext;
      if (state == ARMING) begin
        state <= MONITOR;
      end else if (cause != 3'd0) begin
        state <= FAULT;
        fault <= 1'b1;
        fault_code <= cause;
        lamp <= {4{R}};
        flash <= '0;
      end else begin
        lamp <= cur;
        wd <= same ? wd + 1'b1 : '0;
      end
    end
  end
endmodule

// File: tb/tb_traffic_light_conflict_monitor.sv
// tb_traffic_light_conflict_monitor: directed scenarios for the lamp safety monitor
module tb_traffic_light_conflict_monitor;
  localparam logic [2:0] G = 3'b001, Y = 3'b010, R = 3'b100;
  localparam logic [11:0] ALL_R = {R, R, R, R}, DARK = 12'h000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  traffic_light_conflict_monitor_if bus();
  traffic_light_conflict_monitor dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [11:0] v);
    {bus.light_M1, bus.light_M2, bus.light_MT, bus.light_S} = v;
  endtask

  function automatic logic [11:0] lamps();
    return {bus.lamp_M1, bus.lamp_M2, bus.lamp_MT, bus.lamp_S};
  endfunction

  function automatic logic [3:0] status();
    return {bus.fault, bus.fault_code};
  endfunction

  // reset for two cycles, then one ARMING cycle capturing v
  task automatic start(input logic [11:0] v);
    rst = 1'b1;
    bus.fault_clr = 1'b0;
    drv(v);
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [11:0] round_vec(input int c);
    if (c < 5) return {G, G, R, R};
    if (c < 7) return {G, Y, R, R};
    if (c < 11) return {G, R, G, R};
    if (c < 13) return {Y, R, Y, R};
    if (c < 19) return {R, R, R, G};
    return {R, R, R, Y};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.fault_clr = 1'b0;
    drv({G, G, R, R});
    tick();
    tick();
    checks++;
    if (lamps() !== ALL_R) begin errors++; $display("FAIL reset_lamps got %h want %h", lamps(), ALL_R); end
    checks++;
    if (status() !== 4'h0) begin errors++; $display("FAIL reset_status got %h want 0", status()); end
    rst = 1'b0;
    tick();
    checks++;
    if (lamps() !== ALL_R) begin errors++; $display("FAIL arming_lamps got %h want %h", lamps(), ALL_R); end
  endtask

  task automatic test_legal();
    for (int c = 0; c < 63; c++) begin
      drv(round_vec(c % 21));
      bus.fault_clr = (c % 5 == 0);
      tick();
      checks++;
      if (lamps() !== round_vec(c % 21) || status() !== 4'h0) begin
        errors++;
        $display("FAIL legal_c%0d got lamps %h st %h want lamps %h st 0", c, lamps(), status(), round_vec(c % 21));
      end
    end
    bus.fault_clr = 1'b0;
  endtask

  task automatic test_conflict();
    start(ALL_R);
    drv({G, R, R, G});
    tick();
    checks++;
    if (status() !== 4'hA || lamps() !== ALL_R) begin
      errors++; $display("FAIL conflict_entry got st %h lamps %h want st a lamps %h", status(), lamps(), ALL_R);
    end
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) drv({3'b011, R, R, R});
      tick();
      if (k == 3 || k == 4 || k == 7 || k == 8) begin
        checks++;
        if (lamps() !== ((k == 4 || k == 7) ? DARK : ALL_R)) begin
          errors++; $display("FAIL flash_k%0d got %h want %h", k, lamps(), (k == 4 || k == 7) ? DARK : ALL_R);
        end
      end
    end
    checks++;
    if (status() !== 4'hA) begin errors++; $display("FAIL conflict_hold got %h want a", status()); end
  endtask

  task automatic test_sequence();
    start({R, G, R, R});
    drv({R, R, R, R});
    tick();
    checks++;
    if (status() !== 4'hB) begin errors++; $display("FAIL seq_green_red got %h want b", status()); end
    start(ALL_R);
    drv({R, R, R, Y});
    tick();
    checks++;
    if (status() !== 4'hB) begin errors++; $display("FAIL seq_red_yellow got %h want b", status()); end
    start({R, G, R, R});
    drv({R, Y, R, R});
    tick();
    tick();
    drv(ALL_R);
    tick();
    checks++;
    if (status() !== 4'h0 || lamps() !== ALL_R) begin
      errors++; $display("FAIL yellow_two_ok got st %h lamps %h want st 0 lamps %h", status(), lamps(), ALL_R);
    end
    start({R, G, R, R});
    drv({R, Y, R, R});
    tick();
    checks++;
    if (status() !== 4'h0 || bus.lamp_M2 !== Y) begin
      errors++; $display("FAIL yellow_one_lamp got st %h m2 %h want st 0 m2 %h", status(), bus.lamp_M2, Y);
    end
    drv(ALL_R);
    tick();
    checks++;
    if (status() !== 4'hC) begin errors++; $display("FAIL short_yellow got %h want c", status()); end
  endtask

  task automatic test_encoding();
    start(ALL_R);
    drv({3'b011, R, R, R});
    tick();
    checks++;
    if (status() !== 4'h9 || lamps() !== ALL_R) begin
      errors++; $display("FAIL enc_bad got st %h lamps %h want st 9 lamps %h", status(), lamps(), ALL_R);
    end
    start(ALL_R);
    drv({3'b011, R, R, G});
    tick();
    checks++;
    if (status() !== 4'h9) begin errors++; $display("FAIL enc_priority got %h want 9", status()); end
    start(ALL_R);
    drv({R, R, 3'b000, R});
    tick();
    checks++;
    if (status() !== 4'h9) begin errors++; $display("FAIL enc_dark got %h want 9", status()); end
  endtask

  task automatic test_watchdog();
    start(ALL_R);
    for (int k = 0; k < 15; k++) tick();
    checks++;
    if (status() !== 4'h0) begin errors++; $display("FAIL wd_15_hold got %h want 0", status()); end
    drv({G, R, R, R});
    tick();
    checks++;
    if (status() !== 4'h0 || lamps() !== {G, R, R, R}) begin
      errors++; $display("FAIL wd_change got st %h lamps %h want st 0 lamps %h", status(), lamps(), {G, R, R, R});
    end
    for (int k = 0; k < 15; k++) tick();
    checks++;
    if (status() !== 4'h0) begin errors++; $display("FAIL wd_15_again got %h want 0", status()); end
    tick();
    checks++;
    if (status() !== 4'hD || lamps() !== ALL_R) begin
      errors++; $display("FAIL wd_16 got st %h lamps %h want st d lamps %h", status(), lamps(), ALL_R);
    end
  endtask

  task automatic test_clear();
    start(ALL_R);
    drv({G, R, R, G});
    tick();
    checks++;
    if (status() !== 4'hA) begin errors++; $display("FAIL clr_setup got %h want a", status()); end
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    checks++;
    if (status() !== 4'h0 || lamps() !== ALL_R) begin
      errors++; $display("FAIL clr_wins got st %h lamps %h want st 0 lamps %h", status(), lamps(), ALL_R);
    end
    tick();
    checks++;
    if (status() !== 4'h0) begin errors++; $display("FAIL clr_arming got %h want 0", status()); end
    tick();
    checks++;
    if (status() !== 4'hA) begin errors++; $display("FAIL clr_refault got %h want a", status()); end
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (lamps() !== DARK) begin errors++; $display("FAIL clr_dark got %h want %h", lamps(), DARK); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (status() !== 4'h0 || lamps() !== ALL_R) begin
      errors++; $display("FAIL rst_in_fault got st %h lamps %h want st 0 lamps %h", status(), lamps(), ALL_R);
    end
  endtask

  initial begin
    bus.fault_clr = 1'b0;
    drv(ALL_R);
    test_reset();
    test_legal();
    test_conflict();
    test_sequence();
    test_encoding();
    test_watchdog();
    test_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
